hsv_window_bin: RTL and testbench
=================================

HSV_WINDOW_BIN -- requirements
Module: hsv_window_bin

Interface
REQ-001 SHALL have parameter CH, default 3: number of pixel channels (1..4).
REQ-002 SHALL have parameter W, default 8: bits per channel (4..12).
REQ-003 SHALL have parameter LAT, default 3: input-to-output latency in enabled cycles (2..8).
REQ-004 SHALL have parameter CNT_W, default 24: foreground counter width.
REQ-005 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port ce  in  1: clock enable; 0 freezes all state.
REQ-008 SHALL have ports de_in, hsync_in, vsync_in  in  1 each: video timing, active-high.
REQ-009 SHALL have port pix_in  in  CH*W: pixel; channel k at bits [k*W+W-1 : k*W].
REQ-010 SHALL have ports lo, hi  in  CH*W each: per-channel window bounds, same packing.
REQ-011 SHALL have port mode  in  2: 00 inside-window, 01 outside-window, 10 channel-0-only inside, 11 pass-all.
REQ-012 SHALL have port pix_out  out  CH*W: pix_in delayed by LAT.
REQ-013 SHALL have port mask_out  out  W: all-ones if foreground, else zero.
REQ-014 SHALL have ports de_out, hsync_out, vsync_out  out  1 each: timing delayed by LAT.
REQ-015 SHALL have port fg_count  out  CNT_W: foreground pixel count of last completed frame.
REQ-016 SHALL have port count_valid  out  1: one-cycle pulse when fg_count updates.

Function
REQ-017 SHALL sample pix_in, lo, hi, mode and timing together in the first pipeline stage; later changes to lo/hi/mode SHALL NOT affect pixels already in flight.
REQ-018 SHALL evaluate channel k as in-window when lo_k <= c_k <= hi_k (inclusive, unsigned) if lo_k <= hi_k.
REQ-019 SHALL evaluate channel k as in-window when c_k >= lo_k or c_k <= hi_k if lo_k > hi_k (hue wrap-around).
REQ-020 SHALL set foreground: mode 00 = all channels in-window; 01 = not(all in-window); 10 = channel 0 in-window; 11 = always 1.
REQ-021 SHALL present pix_out, mask_out, de_out, hsync_out, vsync_out exactly LAT enabled cycles after the corresponding input sample.
REQ-022 SHALL force mask_out to zero whenever de_out = 0.
REQ-023 SHALL, with ce = 0, hold every register and output, and SHALL NOT count, detect edges or pulse count_valid.
REQ-024 SHALL increment an internal accumulator by 1 in each enabled cycle with de_out = 1 and mask_out nonzero, saturating at 2^CNT_W - 1.
REQ-025 SHALL detect a frame boundary on an enabled cycle where vsync_out = 1 and vsync_out on the previous enabled cycle was 0.
REQ-026 SHALL, on a frame boundary, load fg_count with the accumulator (including any increment of that cycle), clear the accumulator, and drive count_valid = 1 for exactly that cycle.
REQ-027 SHALL suppress the first frame-boundary pulse after reset if no de_out = 1 cycle has occurred since reset (partial frame not reported).
REQ-028 SHALL keep fg_count unchanged between frame boundaries.

Reset
REQ-029 SHALL, while rst_n = 0, clear all pipeline stages, the accumulator, the previous-vsync register, and the partial-frame flag.
REQ-030 SHALL drive pix_out = 0, mask_out = 0, de_out/hsync_out/vsync_out = 0, fg_count = 0, count_valid = 0 during reset.
REQ-031 SHALL, on reset assertion mid-frame, discard in-flight pixels and the partial count; the next reported frame SHALL count only post-reset pixels.

Verification
REQ-032 SHALL verify window: CH=3, W=8, LAT=3, mode 00, lo={10,40,60}, hi={30,200,255}, pixel {20,100,60} with de=1 -> mask_out=0xFF 3 cycles later; pixel {31,100,60} -> 0x00.
REQ-033 SHALL verify wrap: lo_0=240, hi_0=15, mode 10; c_0 in {250,0,15} -> 0xFF; c_0 in {16,239} -> 0x00.
REQ-034 SHALL verify counting: 4x4 frame, 5 foreground pixels with de=1, then vsync rise -> fg_count=5, count_valid high 1 cycle; second frame with 0 foreground -> fg_count=0 with pulse.
REQ-035 SHALL verify ce: pixel sampled, ce held 0 for 10 cycles then 1 -> output appears after 3 enabled cycles, no count_valid during stall, timing outputs unchanged during stall.
REQ-036 SHALL verify saturation and reset: CNT_W=4, 20 foreground pixels -> fg_count=15; rst_n pulsed low mid-frame -> all outputs 0 asynchronously, next full frame of 3 pixels reports 3.
REQ-037 SHALL verify mode 01/11 and blanking: mode 01 inverts REQ-032 results; mode 11 with de=0 -> mask_out=0x00 and no count.

Source files
------------

// File: rtl/hsv_window_bin.sv
// Per-channel window classifier with a fixed-latency video pipeline and a
// per-frame foreground pixel counter reported on each vsync rising edge.

module hsv_chan_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] c,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic         in_win
);
    // lo > hi describes a window that wraps through zero (e.g. red hue)
    assign in_win = (lo <= hi) ? (c >= lo && c <= hi) : (c >= lo || c <= hi);
endmodule

module hsv_window_bin #(
    parameter int CH    = 3,
    parameter int W     = 8,
    parameter int LAT   = 3,
    parameter int CNT_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                de_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic [CH*W-1:0]     pix_in,
    input  logic [CH*W-1:0]     lo,
    input  logic [CH*W-1:0]     hi,
    input  logic [1:0]          mode,
    output logic [CH*W-1:0]     pix_out,
    output logic [W-1:0]        mask_out,
    output logic                de_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic [CNT_W-1:0]    fg_count,
    output logic                count_valid
);
    logic [CH*W-1:0] lo_s, hi_s;
    logic [1:0]      mode_s;
    logic [CH*W-1:0] pix_pipe [1:LAT];
    logic [2:0]      vld_pipe [1:LAT];   // {vsync, hsync, de}
    logic [LAT:2]    fg_pipe;
    logic [CH-1:0]   in_win;
    logic            fg_s1;

    genvar k;
    for (k = 0; k < CH; k++) begin : g_ch
        hsv_chan_cmp #(.W(W)) u_cmp (
            .c      (pix_pipe[1][k*W +: W]),
            .lo     (lo_s[k*W +: W]),
            .hi     (hi_s[k*W +: W]),
            .in_win (in_win[k])
        );
    end

    always_comb begin
        fg_s1 = 1'b1;
        case (mode_s)
            2'b00:   fg_s1 = &in_win;
            2'b01:   fg_s1 = ~&in_win;
            2'b10:   fg_s1 = in_win[0];
            default: fg_s1 = 1'b1;
        endcase
    end

    // Window bounds and mode travel with the pixel so later changes never
    // reclassify pixels already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_s    <= '0;
            hi_s    <= '0;
            mode_s  <= '0;
            fg_pipe <= '0;
            for (int i = 1; i <= LAT; i++) begin
                pix_pipe[i] <= '0;
                vld_pipe[i] <= '0;
            end
        end else if (ce) begin
            lo_s        <= lo;
            hi_s        <= hi;
            mode_s      <= mode;
            pix_pipe[1] <= pix_in;
            vld_pipe[1] <= {vsync_in, hsync_in, de_in};
            fg_pipe[2]  <= fg_s1;
            for (int i = 2; i <= LAT; i++) begin
                pix_pipe[i] <= pix_pipe[i-1];
                vld_pipe[i] <= vld_pipe[i-1];
            end
            for (int i = 3; i <= LAT; i++)
                fg_pipe[i] <= fg_pipe[i-1];
        end
    end

    assign pix_out   = pix_pipe[LAT];
    assign de_out    = vld_pipe[LAT][0];
    assign hsync_out = vld_pipe[LAT][1];
    assign vsync_out = vld_pipe[LAT][2];
    assign mask_out  = {W{de_out & fg_pipe[LAT]}};

    logic [CNT_W-1:0] acc, acc_nxt;
    logic             prev_vs, armed, hit, frame_edge, report;

    assign hit        = de_out & fg_pipe[LAT];
    assign frame_edge = vsync_out & ~prev_vs;
    // A boundary with no active video seen since reset closes a partial frame
    assign report     = frame_edge & (armed | de_out);
    assign acc_nxt    = (hit && acc != {CNT_W{1'b1}}) ? acc + CNT_W'(1) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            prev_vs     <= 1'b0;
            armed       <= 1'b0;
            fg_count    <= '0;
            count_valid <= 1'b0;
        end else if (ce) begin
            prev_vs     <= vsync_out;
            armed       <= armed | de_out | frame_edge;
            count_valid <= report;
            if (frame_edge) begin
                acc <= '0;
                if (report)
                    fg_count <= acc_nxt;
            end else begin
                acc <= acc_nxt;
            end
        end else begin
            count_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hsv_window_bin.sv
// Directed and random checks of hsv_window_bin against a sample-history model.

module tb_hsv_window_bin;
    localparam int CH = 3, W = 8, LAT = 3, CNT_W = 4;
    localparam int SAT = (1 << CNT_W) - 1;
    localparam logic [23:0] LO_A = {8'd60, 8'd40, 8'd10};
    localparam logic [23:0] HI_A = {8'd255, 8'd200, 8'd30};
    localparam logic [23:0] FGP  = {8'd60, 8'd100, 8'd20};
    localparam logic [23:0] BGP  = {8'd60, 8'd100, 8'd31};

    logic clk = 0, rst_n = 0, ce = 0;
    logic de_in = 0, hsync_in = 0, vsync_in = 0;
    logic [23:0] pix_in = '0, lo = '0, hi = '0;
    logic [1:0]  mode = '0;
    logic [23:0] pix_out;
    logic [7:0]  mask_out;
    logic        de_out, hsync_out, vsync_out, count_valid;
    logic [CNT_W-1:0] fg_count;

    hsv_window_bin #(.CH(CH), .W(W), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pix_in(pix_in), .lo(lo), .hi(hi), .mode(mode),
        .pix_out(pix_out), .mask_out(mask_out),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .fg_count(fg_count), .count_valid(count_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] pix;
        logic        fg;
        logic        de, hs, vs;
    } smp_t;

    smp_t q[$];              // enabled-cycle samples, newest first
    int   m_acc, m_fg;
    bit   m_prev, m_armed, m_cv;
    int   n_pass = 0, n_chk = 0, n_pulse = 0;
    logic [CNT_W-1:0] last_cnt = '0;

    function automatic bit ref_fg(input logic [23:0] p, l, h, input logic [1:0] md);
        int c, lv, hv;
        bit all_in, in0, inw;
        all_in = 1; in0 = 0;
        for (int k = 0; k < CH; k++) begin
            c  = int'(p[k*8 +: 8]);
            lv = int'(l[k*8 +: 8]);
            hv = int'(h[k*8 +: 8]);
            inw = (lv <= hv) ? (c >= lv && c <= hv) : (c >= lv || c <= hv);
            if (k == 0) in0 = inw;
            all_in = all_in && inw;
        end
        case (md)
            2'd0:    return all_in;
            2'd1:    return !all_in;
            2'd2:    return in0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q = {};
        for (int i = 0; i < LAT; i++) q.push_front('0);
        m_acc = 0; m_fg = 0; m_prev = 0; m_armed = 0; m_cv = 0;
    endtask

    task automatic step();
        smp_t cur;
        int   nacc;
        bit   bnd;
        @(posedge clk);
        m_cv = 0;
        if (ce) begin
            cur  = q[LAT-1];
            bnd  = cur.vs && !m_prev;
            nacc = (cur.de && cur.fg && m_acc < SAT) ? m_acc + 1 : m_acc;
            if (bnd) begin
                if (m_armed || cur.de) begin m_fg = nacc; m_cv = 1; end
                m_acc = 0;
            end else m_acc = nacc;
            m_armed = m_armed || cur.de || bnd;
            m_prev  = cur.vs;
            q.push_front('{pix_in, ref_fg(pix_in, lo, hi, mode), de_in, hsync_in, vsync_in});
            void'(q.pop_back());
        end
        #1;
        cur = q[LAT-1];
        check("pix_out", 32'(pix_out), 32'(cur.pix));
        check("mask_out", 32'(mask_out), (cur.de && cur.fg) ? 32'hFF : 32'h0);
        check("timing", 32'({de_out, hsync_out, vsync_out}), 32'({cur.de, cur.hs, cur.vs}));
        check("fg_count", 32'(fg_count), 32'(m_fg));
        check("count_valid", 32'(count_valid), 32'(m_cv));
        if (count_valid === 1'b1) begin n_pulse++; last_cnt = fg_count; end
    endtask

    task automatic drive(input logic [23:0] p, input bit de, hs, vs);
        pix_in = p; de_in = de; hsync_in = hs; vsync_in = vs;
        step();
    endtask

    task automatic probe(input logic [23:0] p, input logic [7:0] exp, input string tag);
        drive(p, 1, 0, 0);
        drive('0, 0, 0, 0);
        drive('0, 0, 0, 0);
        check(tag, 32'(mask_out), 32'(exp));
    endtask

    task automatic vs_pulse();
        drive('0, 0, 0, 1);
        drive('0, 0, 0, 1);
        for (int i = 0; i <= LAT; i++) drive('0, 0, 0, 0);
    endtask

    task automatic frame(input int npix, input int nfg, input int exp, input string tag);
        int p0;
        for (int i = 0; i < npix; i++) begin
            drive(i < nfg ? FGP : BGP, 1, 0, 0);
            if (i % 4 == 3) drive('0, 0, 1, 0);
        end
        p0 = n_pulse;
        vs_pulse();
        check({tag, "_pulses"}, 32'(n_pulse - p0), 32'd1);
        check({tag, "_count"}, 32'(last_cnt), 32'(exp));
    endtask

    initial begin
        int p0;
        logic [2:0] tim0;
        logic [7:0] wrap_c [5] = '{8'd250, 8'd0, 8'd15, 8'd16, 8'd239};
        logic [7:0] wrap_m [5] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};

        #3;
        check("rst_pix", 32'(pix_out), 0);
        check("rst_mask", 32'(mask_out), 0);
        check("rst_timing", 32'({de_out, hsync_out, vsync_out}), 0);
        check("rst_count", 32'({fg_count, count_valid}), 0);
        model_reset();
        rst_n = 1; ce = 1;

        lo = LO_A; hi = HI_A; mode = 2'b00;
        probe(FGP, 8'hFF, "win_in");
        probe(BGP, 8'h00, "win_out");
        mode = 2'b01;
        probe(FGP, 8'h00, "inv_in");
        probe(BGP, 8'hFF, "inv_out");

        lo = 24'h0000F0; hi = 24'h00000F; mode = 2'b10;
        for (int i = 0; i < 5; i++) probe({16'h0, wrap_c[i]}, wrap_m[i], "wrap");

        lo = LO_A; hi = HI_A; mode = 2'b00;
        vs_pulse();
        frame(16, 5, 5, "frame5");
        frame(16, 0, 0, "frame0");

        mode = 2'b11;
        for (int i = 0; i < 4; i++) drive(FGP, 0, 0, 0);
        check("pass_blank_mask", 32'(mask_out), 0);
        p0 = n_pulse;
        vs_pulse();
        check("pass_blank_pulse", 32'(n_pulse - p0), 1);
        check("pass_blank_count", 32'(last_cnt), 0);

        mode = 2'b00;
        drive(FGP, 1, 0, 1);
        ce = 0; p0 = n_pulse;
        tim0 = {de_out, hsync_out, vsync_out};
        for (int i = 0; i < 10; i++) begin
            pix_in = 24'($urandom); de_in = 1'($urandom); vsync_in = 1'($urandom);
            step();
            check("stall_timing", 32'({de_out, hsync_out, vsync_out}), 32'(tim0));
        end
        check("stall_no_pulse", 32'(n_pulse - p0), 0);
        ce = 1;
        drive('0, 0, 0, 0);
        drive('0, 0, 0, 0);
        check("stall_mask", 32'(mask_out), 32'hFF);
        check("stall_vsync", 32'(vsync_out), 1);
        drive('0, 0, 0, 0);
        check("stall_pulse_after", 32'({count_valid, fg_count}), 32'({1'b1, 4'd1}));
        vs_pulse();

        frame(20, 20, SAT, "sat");

        for (int i = 0; i < 4; i++) drive(FGP, 1, 0, 0);
        #2 rst_n = 0;
        #1;
        check("arst_pix", 32'(pix_out), 0);
        check("arst_mask", 32'(mask_out), 0);
        check("arst_timing", 32'({de_out, hsync_out, vsync_out}), 0);
        check("arst_count", 32'({fg_count, count_valid}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        frame(3, 3, 3, "post_rst");

        for (int i = 0; i < 400; i++) begin
            ce   = ($urandom_range(0, 9) != 0);
            lo   = 24'($urandom); hi = 24'($urandom);
            mode = 2'($urandom);
            drive(24'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
